// File: rtl/pause_fade.sv
// pause_fade: merges user toggle, OSD pause and core pause requests into one
// CPU halt line, supports single-frame stepping while user-paused, and fades
// the RGB stream in per-frame right-shift stages after a paused idle period.
//
// Step FSM states:
//   state | meaning
//   IDLE  | paused (or running), no step in progress
//   WAIT  | step requested, waiting for the next frame boundary
//   RUN1  | CPU released for exactly one frame, ends at next frame boundary
module pause_fade #(
  parameter int RW         = 8,
  parameter int GW         = 8,
  parameter int BW         = 8,
  parameter int NREQ       = 1,
  parameter int DIM_CYCLES = 240000000,
  parameter int FADE_STEPS = 2,
  localparam int W         = RW + GW + BW,
  localparam int DW        = $clog2(FADE_STEPS + 1)
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            user_button,
  input  logic [NREQ-1:0] pause_request,
  input  logic            osd_status,
  input  logic [1:0]      options,
  input  logic            step,
  input  logic            vblank,
  input  logic [W-1:0]    rgb_in,
  output logic [W-1:0]    rgb_out,
  output logic            pause_cpu,
  output logic [DW-1:0]   dim_level
);

  localparam int TW = $clog2(DIM_CYCLES + 1);
  localparam logic [TW-1:0] DIM_MAX  = TW'(DIM_CYCLES);
  localparam logic [DW-1:0] FADE_MAX = DW'(FADE_STEPS);

  typedef enum logic [1:0] {IDLE, WAIT, RUN1} state_t;

  state_t        state, state_nxt;
  logic          btn_q, step_q, vb_q;
  logic          btn_edge, step_edge, vb_edge;
  logic          user_pause;
  logic          ext_pause;
  logic          step_take;
  logic          dim_clear;
  logic [TW-1:0] timer;
  logic [DW-1:0] dim_eff;
  logic [RW-1:0] r_dim;
  logic [GW-1:0] g_dim;
  logic [BW-1:0] b_dim;

  assign btn_edge  = user_button & ~btn_q;
  assign step_edge = step & ~step_q;
  assign vb_edge   = vblank & ~vb_q;
  assign ext_pause = (|pause_request) | (options[0] & osd_status);
  // A toggle in the same cycle wins over a step; steps only count while user-paused.
  assign step_take = step_edge & user_pause & ~btn_edge;
  assign dim_clear = ~pause_cpu | ~options[1] | step_take;
  // Cancelling the fade takes effect on the pixel path in the same cycle.
  assign dim_eff   = dim_clear ? '0 : dim_level;

  // Previous-value registers for the three edge detectors.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_q  <= 1'b0;
      step_q <= 1'b0;
      vb_q   <= 1'b0;
    end else begin
      btn_q  <= user_button;
      step_q <= step;
      vb_q   <= vblank;
    end
  end

  // User pause toggle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) user_pause <= 1'b0;
    else if (btn_edge) user_pause <= ~user_pause;
  end

  // Step FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end

  // Step FSM next state; leaving user pause always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (!user_pause || btn_edge) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (step_edge) state_nxt = WAIT;
        WAIT:    if (vb_edge)   state_nxt = RUN1;
        RUN1:    if (vb_edge)   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered CPU halt; external requests override stepping.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) pause_cpu <= 1'b0;
    else pause_cpu <= (user_pause & (state != RUN1)) | ext_pause;
  end

  // Idle timer and per-frame fade level.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      timer     <= '0;
      dim_level <= '0;
    end else if (dim_clear) begin
      timer     <= '0;
      dim_level <= '0;
    end else if (timer != DIM_MAX) begin
      timer <= timer + 1'b1;
    end else if (vb_edge && (dim_level != FADE_MAX)) begin
      dim_level <= dim_level + 1'b1;
    end
  end

  // Per-channel zero-fill shift.
  always_comb begin
    r_dim = rgb_in[W-1 -: RW] >> dim_eff;
    g_dim = rgb_in[GW+BW-1 -: GW] >> dim_eff;
    b_dim = rgb_in[BW-1:0] >> dim_eff;
  end

  // Registered pixel output.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rgb_out <= '0;
    else rgb_out <= {r_dim, g_dim, b_dim};
  end

endmodule

// File: tb/tb_pause_fade.sv
// Directed bench for pause_fade: option/request table plus hand sequences for
// toggle latency, frame step, fade, fade cancel, collisions and async reset.
module tb_pause_fade;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        user_button;
  logic [1:0]  pause_request;
  logic        osd_status;
  logic [1:0]  options;
  logic        step;
  logic        vblank;
  logic [23:0] rgb_in;
  logic [23:0] rgb_out;
  logic        pause_cpu;
  logic [1:0]  dim_level;

  int errors = 0;
  int checks = 0;

  pause_fade #(
    .RW(8), .GW(8), .BW(8), .NREQ(2), .DIM_CYCLES(100), .FADE_STEPS(2)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .user_button(user_button),
    .pause_request(pause_request), .osd_status(osd_status), .options(options),
    .step(step), .vblank(vblank), .rgb_in(rgb_in), .rgb_out(rgb_out),
    .pause_cpu(pause_cpu), .dim_level(dim_level)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0]  opt;
    logic        osd;
    logic [1:0]  preq;
    logic [23:0] rgb;
    logic        exp_pause;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press_button();
    user_button = 1'b1;
    tick();
    user_button = 1'b0;
    tick();
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
  endtask

  // Frames of 20 cycles, vblank high for 4; records which samples had pause_cpu low.
  task automatic run_frames(input int nrise, input logic step_at0,
                            output int first_low, output int last_low, output int nlow);
    first_low = -1;
    last_low  = -1;
    nlow      = 0;
    for (int i = 0; i < 20 * nrise + 5; i++) begin
      vblank = (i < 20 * nrise) && ((i % 20) < 4);
      step   = step_at0 && (i == 0);
      tick();
      if (!pause_cpu) begin
        if (first_low < 0) first_low = i;
        last_low = i;
        nlow++;
      end
    end
    vblank = 1'b0;
    step   = 1'b0;
  endtask

  int fl, ll, nl;

  initial begin
    vecs[0] = '{opt: 2'b01, osd: 1'b1, preq: 2'b00, rgb: 24'h123456, exp_pause: 1'b1};
    vecs[1] = '{opt: 2'b00, osd: 1'b1, preq: 2'b00, rgb: 24'hABCDEF, exp_pause: 1'b0};
    vecs[2] = '{opt: 2'b00, osd: 1'b0, preq: 2'b10, rgb: 24'h000001, exp_pause: 1'b1};
    vecs[3] = '{opt: 2'b11, osd: 1'b0, preq: 2'b01, rgb: 24'hFFFFFF, exp_pause: 1'b1};
    vecs[4] = '{opt: 2'b10, osd: 1'b1, preq: 2'b00, rgb: 24'h808080, exp_pause: 1'b0};
    vecs[5] = '{opt: 2'b01, osd: 1'b0, preq: 2'b00, rgb: 24'h7F0102, exp_pause: 1'b0};
    vecs[6] = '{opt: 2'b00, osd: 1'b0, preq: 2'b11, rgb: 24'h55AA55, exp_pause: 1'b1};
    vecs[7] = '{opt: 2'b00, osd: 1'b0, preq: 2'b00, rgb: 24'h0F0F0F, exp_pause: 1'b0};

    reset_n = 1'b0; user_button = 1'b0; pause_request = 2'b11; osd_status = 1'b1;
    options = 2'b11; step = 1'b0; vblank = 1'b0; rgb_in = 24'hFF8040;
    ticks(3);
    check("reset_pause_cpu", {31'd0, pause_cpu}, 32'd0);
    check("reset_rgb_out", {8'd0, rgb_out}, 32'd0);
    check("reset_dim_level", {30'd0, dim_level}, 32'd0);
    pause_request = 2'b00; osd_status = 1'b0; options = 2'b00;
    reset_n = 1'b1;
    ticks(2);

    // Option / request table, user_pause = 0.
    for (int k = 0; k < 8; k++) begin
      options = vecs[k].opt; osd_status = vecs[k].osd;
      pause_request = vecs[k].preq; rgb_in = vecs[k].rgb;
      tick();
      check($sformatf("vec%0d_pause_cpu", k), {31'd0, pause_cpu}, {31'd0, vecs[k].exp_pause});
      check($sformatf("vec%0d_rgb_out", k), {8'd0, rgb_out}, {8'd0, vecs[k].rgb});
    end
    options = 2'b00; osd_status = 1'b0; pause_request = 2'b00;
    ticks(2);

    // Toggle latency: change visible two cycles after the press.
    user_button = 1'b1; tick();
    check("toggle_on_n1", {31'd0, pause_cpu}, 32'd0);
    user_button = 1'b0; tick();
    check("toggle_on_n2", {31'd0, pause_cpu}, 32'd1);
    user_button = 1'b1; tick();
    check("toggle_off_n1", {31'd0, pause_cpu}, 32'd1);
    user_button = 1'b0; tick();
    check("toggle_off_n2", {31'd0, pause_cpu}, 32'd0);

    // Step while unpaused is ignored: pause afterwards, frames keep pause_cpu high.
    step = 1'b1; tick(); step = 1'b0; tick();
    press_button();
    run_frames(2, 1'b0, fl, ll, nl);
    check("step_unpaused_lows", nl, 0);

    // Normal frame step while paused.
    step = 1'b1; tick(); step = 1'b0; tick();
    run_frames(2, 1'b0, fl, ll, nl);
    check("step_low_count", nl, 20);
    check("step_first_low", fl, 1);
    check("step_last_low", ll, 20);
    check("step_end_pause", {31'd0, pause_cpu}, 32'd1);

    // Step and vblank edge together in IDLE: that vblank does not count.
    run_frames(3, 1'b1, fl, ll, nl);
    check("stepvb_low_count", nl, 20);
    check("stepvb_first_low", fl, 21);

    // Fade sequence.
    press_button();                       // unpause
    ticks(2);
    options = 2'b10; rgb_in = 24'hFF8040;
    press_button();                       // pause, timer starts
    check("fade_paused", {31'd0, pause_cpu}, 32'd1);
    ticks(50);
    vb_pulse();
    check("fade_early_vb_dim", {30'd0, dim_level}, 32'd0);
    ticks(70);
    vb_pulse();
    check("fade_dim1", {30'd0, dim_level}, 32'd1);
    tick();
    check("fade_rgb1", {8'd0, rgb_out}, 32'h7F4020);
    ticks(5);
    vb_pulse();
    check("fade_dim2", {30'd0, dim_level}, 32'd2);
    tick();
    check("fade_rgb2", {8'd0, rgb_out}, 32'h3F2010);
    ticks(5);
    vb_pulse();
    tick();
    check("fade_dim_sat", {30'd0, dim_level}, 32'd2);
    check("fade_rgb_sat", {8'd0, rgb_out}, 32'h3F2010);

    // Cancel by step edge: undimmed on the next cycle.
    step = 1'b1; tick(); step = 1'b0;
    check("cancel_step_dim", {30'd0, dim_level}, 32'd0);
    check("cancel_step_rgb", {8'd0, rgb_out}, 32'hFF8040);

    // Timer restarts from zero: re-pause, early vblank does not fade, later one does.
    press_button();
    press_button();
    ticks(50);
    vb_pulse();
    check("restart_early_dim", {30'd0, dim_level}, 32'd0);
    ticks(60);
    vb_pulse();
    check("restart_dim1", {30'd0, dim_level}, 32'd1);

    // Cancel by unpause.
    press_button();
    tick();
    check("cancel_unpause_cpu", {31'd0, pause_cpu}, 32'd0);
    check("cancel_unpause_dim", {30'd0, dim_level}, 32'd0);
    check("cancel_unpause_rgb", {8'd0, rgb_out}, 32'hFF8040);
    options = 2'b00;
    ticks(2);

    // Button and step edges together: toggle taken, step ignored.
    user_button = 1'b1; step = 1'b1; tick();
    user_button = 1'b0; step = 1'b0; tick();
    check("collide_paused", {31'd0, pause_cpu}, 32'd1);
    run_frames(2, 1'b0, fl, ll, nl);
    check("collide_no_step", nl, 0);

    // Async reset while in RUN1.
    step = 1'b1; tick(); step = 1'b0; tick();
    vblank = 1'b1; tick(); vblank = 1'b0; ticks(2);
    check("run1_released", {31'd0, pause_cpu}, 32'd0);
    pause_request = 2'b01;
    tick();
    check("run1_ext_override", {31'd0, pause_cpu}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pause", {31'd0, pause_cpu}, 32'd0);
    check("async_rst_rgb", {8'd0, rgb_out}, 32'd0);
    check("async_rst_dim", {30'd0, dim_level}, 32'd0);
    pause_request = 2'b00;
    tick();
    reset_n = 1'b1;
    ticks(2);
    check("post_rst_pause", {31'd0, pause_cpu}, 32'd0);
    press_button();
    check("post_rst_repause", {31'd0, pause_cpu}, 32'd1);
    run_frames(2, 1'b0, fl, ll, nl);
    check("post_rst_idle", nl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
